// File: rtl/debug_led_sequencer_if.sv
// debug_led_sequencer_if
//   Groups the status-requester side and the LED side of the debug LED sequencer.
//   master : the status sources / system top (drives req, code; observes the rest)
//   slave  : debug_led_sequencer
//   Signals:
//     req[NUM_REQ]          per-requester request, held high until acked
//     code[NUM_REQ*CODE_W]  requester i's blink code in bits [i*CODE_W +: CODE_W]
//     ack[NUM_REQ]          one-cycle grant pulse to the served requester
//     busy                  high while a code is playing
//     active_id[ID_W]       index of the requester being played, 0 when idle
//     debug_led             LED drive, active-high
interface debug_led_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int CODE_W  = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*CODE_W-1:0] code;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [ID_W-1:0]           active_id;
  logic                      debug_led;

  modport master (output req, code, input ack, busy, active_id, debug_led);
  modport slave  (input req, code, output ack, busy, active_id, debug_led);
endinterface

// File: rtl/debug_led_sequencer.sv
// debug_led_sequencer
//   Shares one debug LED between NUM_REQ status requesters. A granted requester's
//   blink code (a pulse count) is played as ON/OFF pulses followed by a gap; when
//   nothing is playing the LED shows a heartbeat square wave.
//   Ports:
//     clk_50  system clock, rising edge
//     reset   synchronous, active-high
//     bus     debug_led_sequencer_if.slave (req/code in; ack/busy/active_id/debug_led out)
module debug_led_sequencer #(
  parameter int NUM_REQ   = 4,
  parameter int CODE_W    = 4,
  parameter int TICK_DIV  = 1048576,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4,
  parameter int HB_TICKS  = 8
) (
  input  logic                  clk_50,
  input  logic                  reset,
  debug_led_sequencer_if.slave  bus
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int MAX_AB = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_CD = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0]   ON_LAST  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0]   OFF_LAST = TMR_W'(OFF_TICKS - 1);
  localparam logic [TMR_W-1:0]   GAP_LAST = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0]   HB_LAST  = TMR_W'(HB_TICKS - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t              r_state;
  logic [PRE_W-1:0]    r_presc;
  logic [TMR_W-1:0]    r_tmr;
  logic [CODE_W-1:0]   r_pulse;
  logic                r_hb;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_busy;
  logic [ID_W-1:0]     r_active_id;
  logic                r_led;

  logic                w_tick;
  logic                w_phase_done;
  logic                w_gnt_any;
  logic                w_gnt_ok;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [CODE_W-1:0]   w_gnt_code;

  assign w_tick = (r_presc == PRE_LAST);

  // The tick timer is shared: it times the current phase, or the heartbeat half-period in IDLE.
  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      S_IDLE:  w_phase_done = w_tick && (r_tmr == HB_LAST);
      S_ON:    w_phase_done = w_tick && (r_tmr == ON_LAST);
      S_OFF:   w_phase_done = w_tick && (r_tmr == OFF_LAST);
      S_GAP:   w_phase_done = w_tick && (r_tmr == GAP_LAST);
      default: w_phase_done = 1'b0;
    endcase
  end

  // Fixed priority: scanning downward lets the lowest requesting index win.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_code = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = ID_W'(i);
        w_gnt_code = bus.code[i*CODE_W +: CODE_W];
      end
    end
  end

  // While an ack is on the wire the requester has not yet seen it and still holds req;
  // granting again that cycle would double-ack a zero-code requester.
  assign w_gnt_ok = w_gnt_any && (r_ack == '0);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_tmr       <= '0;
      r_pulse     <= '0;
      r_hb        <= 1'b0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_led       <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_tmr <= w_phase_done ? '0 : r_tmr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt_ok) begin
            r_ack <= ACK_ONE << w_gnt_idx;
          end
          if (w_gnt_ok && (w_gnt_code != '0)) begin
            r_state     <= S_ON;
            r_pulse     <= w_gnt_code;
            r_active_id <= w_gnt_idx;
            r_busy      <= 1'b1;
            r_led       <= 1'b1;
            r_presc     <= '0;
            r_tmr       <= '0;
          end else if (w_phase_done) begin
            r_hb  <= ~r_hb;
            r_led <= ~r_hb;
          end
        end
        S_ON: begin
          if (w_phase_done) begin
            r_state <= S_OFF;
            r_pulse <= r_pulse - 1'b1;
            r_led   <= 1'b0;
            r_presc <= '0;
          end
        end
        S_OFF: begin
          if (w_phase_done) begin
            r_presc <= '0;
            if (r_pulse != '0) begin
              r_state <= S_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_phase_done) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_active_id <= '0;
            r_hb        <= 1'b0;
            r_led       <= 1'b0;
            r_presc     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active_id;
  assign bus.debug_led = r_led;

endmodule
